// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle add/subtract: one shared 4-bit carry-lookahead slice, LS nibble first,
// with the carry between nibbles held in a register.
//
// state  | meaning
// IDLE   | ready for a request; outputs hold the last completed result
// RUN    | one nibble per clock through the lookahead slice
// DONE   | one-cycle done_o pulse; result and flags valid
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [CW+1:0]    w_base;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_sum;
  logic [WIDTH-1:0] w_result_next;
  logic             w_last;

  always_comb begin
    w_base  = {r_cnt, 2'b00};
    w_a_nib = r_a[w_base +: 4];
    w_b_nib = r_b[w_base +: 4];
    w_g     = w_a_nib & w_b_nib;
    w_p     = w_a_nib ^ w_b_nib;
    // Flat sum-of-products carries; no carry ripples through the slice.
    w_c[0]  = r_carry;
    w_c[1]  = w_g[0] | (w_p[0] & w_c[0]);
    w_c[2]  = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    w_c[3]  = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
            | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_c[4]  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
            | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_sum   = w_p ^ w_c[3:0];
    w_result_next = r_result;
    w_result_next[w_base +: 4] = w_sum;
    w_last  = (r_cnt == LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a      <= a_i;
            r_b      <= sub_i ? ~b_i : b_i;
            r_carry  <= sub_i;
            r_result <= '0;
            r_cnt    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_result_next;
          r_carry  <= w_c[4];
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_cout  <= w_c[4];
            r_ovf   <= w_c[4] ^ w_c[3];
            r_zero  <= (w_result_next == '0);
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o    = (r_state == S_IDLE);
  assign done_o     = (r_state == S_DONE);
  assign result_o   = r_result;
  assign cout_o     = r_cout;
  assign overflow_o = r_ovf;
  assign zero_o     = r_zero;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Bench for cla_seq_adder_ctrl: a 32-bit and an 8-bit instance checked every cycle
// against an arithmetic reference model, plus literal expectations for directed cases.
module tb_cla_seq_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        s32_start = 1'b0, s32_sub = 1'b0;
  logic [31:0] s32_a = '0, s32_b = '0;
  logic        ready32, done32, cout32, ovf32, zero32;
  logic [31:0] res32;

  logic        s8_start = 1'b0, s8_sub = 1'b0;
  logic [7:0]  s8_a = '0, s8_b = '0;
  logic        ready8, done8, cout8, ovf8, zero8;
  logic [7:0]  res8;

  cla_seq_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(s32_start), .sub_i(s32_sub),
    .a_i(s32_a), .b_i(s32_b), .ready_o(ready32), .done_o(done32),
    .result_o(res32), .cout_o(cout32), .overflow_o(ovf32), .zero_o(zero32));

  cla_seq_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(s8_start), .sub_i(s8_sub),
    .a_i(s8_a), .b_i(s8_b), .ready_o(ready8), .done_o(done8),
    .result_o(res8), .cout_o(cout8), .overflow_o(ovf8), .zero_o(zero8));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {zero, overflow, cout, result} from plain integer arithmetic.
  function automatic logic [34:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input int w);
    longint mod, ua, ub, sa, sb, r, t;
    logic c, v;
    mod = longint'(1) << w;
    ua  = longint'(a) & (mod - 1);
    ub  = longint'(b) & (mod - 1);
    sa  = (ua >= mod / 2) ? ua - mod : ua;
    sb  = (ub >= mod / 2) ? ub - mod : ub;
    if (s) begin
      r = ua - ub; c = (ua >= ub); t = sa - sb;
    end else begin
      r = ua + ub; c = (r >= mod); t = sa + sb;
    end
    if (r < 0) r += mod;
    if (r >= mod) r -= mod;
    v = (t >= mod / 2) || (t < -(mod / 2));
    return {(r == 0), v, c, 32'(r)};
  endfunction

  // Reference: busy for NIB+2 edges after acceptance, results published on the done cycle.
  bit          m32_busy = 0, m8_busy = 0;
  int          m32_age = 0, m8_age = 0;
  logic [34:0] m32_out = '0, m8_out = '0, m32_pend = '0, m8_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m32_busy = 0; m32_age = 0; m32_out = '0;
    end else if (!m32_busy) begin
      if (s32_start) begin
        m32_busy = 1; m32_age = 0; m32_out = '0;
        m32_pend = golden(s32_a, s32_b, s32_sub, 32);
      end
    end else begin
      m32_age++;
      if (m32_age == 8) m32_out = m32_pend;
      if (m32_age == 9) m32_busy = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_busy = 0; m8_age = 0; m8_out = '0;
    end else if (!m8_busy) begin
      if (s8_start) begin
        m8_busy = 1; m8_age = 0; m8_out = '0;
        m8_pend = golden({24'h0, s8_a}, {24'h0, s8_b}, s8_sub, 8);
      end
    end else begin
      m8_age++;
      if (m8_age == 2) m8_out = m8_pend;
      if (m8_age == 3) m8_busy = 0;
    end
  end

  always @(negedge clk) begin
    chk("ready32", ready32, !m32_busy);
    chk("done32", done32, m32_busy && m32_age == 8);
    chk("flags32", {zero32, ovf32, cout32}, m32_out[34:32]);
    if (!m32_busy || m32_age == 8) chk("result32", res32, m32_out[31:0]);
    chk("ready8", ready8, !m8_busy);
    chk("done8", done8, m8_busy && m8_age == 2);
    chk("flags8", {zero8, ovf8, cout8}, m8_out[34:32]);
    if (!m8_busy || m8_age == 2) chk("result8", res8, m8_out[7:0]);
  end

  // exp_f = {zero, overflow, cout}
  task automatic run32(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] exp_res, input logic [2:0] exp_f,
                       input bit inject);
    int lat;
    lat = -1;
    @(negedge clk);
    s32_start = 1; s32_a = a; s32_b = b; s32_sub = s;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) s32_start = 0;
      if (inject && i == 3) begin
        s32_start = 1; s32_a = 32'hDEAD_BEEF; s32_b = 32'h0BAD_F00D; s32_sub = 1;
      end
      if (inject && i == 4) s32_start = 0;
      if (inject) chk({nm, "_ready_busy"}, ready32, 1'b0);
      if (done32) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_result"}, res32, exp_res);
    chk({nm, "_flags"}, {zero32, ovf32, cout32}, exp_f);
    @(negedge clk);
    chk({nm, "_done_once"}, done32, 1'b0);
    chk({nm, "_ready_back"}, ready32, 1'b1);
  endtask

  initial begin
    int d1, d2;
    bit seen;
    #1 rst = 1;
    #1;
    chk("rst_ready32", ready32, 1'b1);
    chk("rst_done32", done32, 1'b0);
    chk("rst_out32", {res32, zero32, ovf32, cout32}, 35'h0);
    chk("rst_ready8", ready8, 1'b1);
    repeat (2) @(negedge clk);
    rst = 0;

    run32("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 0, 32'h0000_0000, 3'b101, 0);
    run32("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 3'b010, 0);
    run32("sub_neg",  32'h0000_0005, 32'h0000_0007, 1, 32'hFFFF_FFFE, 3'b000, 0);
    run32("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 3'b011, 0);
    run32("ignore",   32'h1234_5678, 32'h1111_1111, 0, 32'h2345_6789, 3'b000, 1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    s32_start = 1; s32_a = 32'hAAAA_5555; s32_b = 32'h1357_9BDF; s32_sub = 0;
    @(negedge clk);
    s32_start = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_ready", ready32, 1'b1);
    chk("abort_done", done32, 1'b0);
    chk("abort_out", {res32, zero32, ovf32, cout32}, 35'h0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done32) seen = 1;
    end
    chk("abort_no_done", seen, 1'b0);
    run32("after_rst", 32'h0000_0002, 32'h0000_0003, 0, 32'h0000_0005, 3'b000, 0);

    // 8-bit instance with start held high across two operations.
    d1 = -1; d2 = -1;
    @(negedge clk);
    s8_start = 1; s8_a = 8'hFF; s8_b = 8'h01; s8_sub = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8 && d1 < 0) begin
        d1 = cyc;
        chk("w8_first_result", res8, 8'h00);
        chk("w8_first_flags", {zero8, ovf8, cout8}, 3'b101);
        s8_a = 8'h80; s8_b = 8'h01; s8_sub = 1;
      end else if (done8) begin
        d2 = cyc;
        chk("w8_second_result", res8, 8'h7F);
        chk("w8_second_flags", {zero8, ovf8, cout8}, 3'b011);
        s8_start = 0;
        break;
      end
    end
    chk("w8_spacing", d2 - d1, 4);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
- Multi-cycle add/subtract controller. Performs a WIDTH-bit operation by sequencing one shared 4-bit carry-lookahead slice, processing one nibble per cycle, least-significant nibble first.
- Carry-out of each nibble is registered and becomes carry-in of the next nibble.
- Serves the ALU path where area matters more than latency. The upstream requester talks to it through a start/ready/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of slice iterations (derived, not overridable).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- start_i  input  1  request; accepted only on a rising edge where ready_o=1.
- sub_i  input  1  0 = A+B, 1 = A-B; sampled with start.
- a_i  input  WIDTH  operand A; sampled with start.
- b_i  input  WIDTH  operand B; sampled with start.
- ready_o  output  1  controller idle, can accept start.
- done_o  output  1  one-cycle pulse: result and flags are valid.
- result_o  output  WIDTH  sum/difference.
- cout_o  output  1  carry out of the MSB (for subtract: 1 = no borrow).
- overflow_o  output  1  signed (two's complement) overflow.
- zero_o  output  1  result_o == 0.

Behaviour:
- Reset: one clock, clk_i; asynchronous active-high reset rst_i. Effects of rst_i=1:
  - state=IDLE, nibble counter=0, carry register=0, latched operands=0.
  - result_o, cout_o, overflow_o, zero_o, done_o = 0; ready_o=1.
  - Reset mid-operation aborts immediately; no done_o is produced for the aborted request.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On an edge with start_i=1: latch a_i, latch (sub_i ? ~b_i : b_i), and set carry register = sub_i.
  - Clear result register, set counter=0, go to RUN.
- RUN:
  - ready_o=0.
  - Each edge processes slice k=counter. Slice inputs are A[4k+3:4k], B'[4k+3:4k] and the carry register.
  - Per bit: G=a&b', P=a^b'. Lookahead carries c1..c4 are computed as full sum-of-products (no ripple).
  - Sum nibble = P ^ {c3,c2,c1,cin} is written to result[4k+3:4k]. Carry register <= c4.
  - Counter increments. When k=NIB-1, go to DONE.
  - Flag captures on the last slice:
    - cout_o <= c4.
    - overflow_o <= c4 ^ c3 (carry into MSB vs carry out of MSB).
    - zero_o <= (full result including the final nibble) == 0.
- DONE:
  - done_o=1 for exactly one cycle; ready_o=0.
  - Next edge: IDLE unconditionally.
- Latency: start sampled at edge E0; done_o is high during the cycle after edge E0+NIB; ready_o rises after edge E0+NIB+1.
  - WIDTH=32: 8 RUN cycles, done on the 9th cycle.
- start_i while in RUN or DONE is ignored (not queued). a_i/b_i/sub_i changes during RUN have no effect.
- Output holding: result_o and flags hold their last completed values from DONE until the next accepted start, at which point they clear to 0.
  - Intermediate nibbles are visible on result_o during RUN; consumers use only done_o.
- Wrap-around: the arithmetic is modulo 2^WIDTH. The carry out of the MSB is reported only via cout_o.
- Back-to-back: a start asserted continuously is accepted in IDLE on the edge after DONE. Throughput is one operation per NIB+2 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. WIDTH=32, add 0x0000_0001 + 0xFFFF_FFFF -> after 8 RUN cycles, done_o pulse with result_o=0x0000_0000, cout_o=1, zero_o=1, overflow_o=0.
2. Add 0x7FFF_FFFF + 0x0000_0001 -> result_o=0x8000_0000, overflow_o=1, cout_o=0, zero_o=0. Also check done_o is high exactly one cycle, at edge E0+8.
3. Subtract 0x0000_0005 - 0x0000_0007 -> result_o=0xFFFF_FFFE, cout_o=0, overflow_o=0. Then subtract 0x8000_0000 - 0x0000_0001 -> 0x7FFF_FFFF, overflow_o=1, cout_o=1.
4. Start 0x1234_5678 + 0x1111_1111. Pulse start_i with other operands during RUN cycle 3 -> ignored; result_o=0x2345_6789; ready_o stays 0 through DONE.
5. Assert rst_i asynchronously mid-clock at RUN cycle 4 -> all outputs 0 and ready_o=1 immediately, no done_o. A following start of 2+3 yields 0x0000_0005.
6. WIDTH=8 instance with start held high: 0xFF+0x01 then 0x80-0x01 back-to-back.
   - First result: 0x00, cout_o=1, zero_o=1.
   - Second result: 0x7F, overflow_o=1.
   - Spacing between done_o pulses: 4 cycles.
